// File: rtl/guess_pkg.sv
// guess_pkg: shared types and constants for the guessing-game round controller.
//   game_state_t : round state reported on guess_round_ctrl.state
//   HINT_*       : bit positions inside the 3-bit hint vector {lt,gt,eq}
package guess_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_WON  = 2'd2,
        S_LOST = 2'd3
    } game_state_t;

    localparam int HINT_EQ = 0;
    localparam int HINT_GT = 1;
    localparam int HINT_LT = 2;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: conditions one raw active-low push-button.
//   CLOCK_50    : system clock
//   rst_n       : asynchronous active-low reset
//   key_n       : raw button, active-low, asynchronous to CLOCK_50
//   press_pulse : one-cycle pulse, registered, one cycle after the debounced
//                 level falls (release produces nothing)
// A level must stay stable at the synchroniser output for DEBOUNCE_CYCLES
// consecutive cycles before it is accepted.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic CLOCK_50,
    input  logic rst_n,
    input  logic key_n,
    output logic press_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic             deb_q;
    logic             deb_d1;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       valid_sr;
    logic             armed;

    // valid_sr marks when sync_2 carries a real sample of key_n rather than
    // its reset value. armed only sets once a released key is seen both at the
    // synchroniser and at the debounced level, so a key held through reset
    // release is swallowed until it is released and pressed again.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync_1      <= 1'b1;
            sync_2      <= 1'b1;
            deb_q       <= 1'b1;
            deb_d1      <= 1'b1;
            cnt         <= '0;
            valid_sr    <= 2'b00;
            armed       <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            sync_1   <= key_n;
            sync_2   <= sync_1;
            valid_sr <= {valid_sr[0], 1'b1};
            deb_d1   <= deb_q;

            if (sync_2 == deb_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb_q <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (valid_sr[1] && sync_2 && deb_q) begin
                armed <= 1'b1;
            end

            press_pulse <= armed & deb_d1 & ~deb_q;
        end
    end

endmodule

// File: rtl/guess_round_ctrl.sv
// guess_round_ctrl: round controller for the guessing game.
//   CLOCK_50, rst_n            : clock, asynchronous active-low reset
//   key_store_n, key_submit_n  : raw active-low push-buttons
//   eq, gt, lt                 : comparator results (guess vs secret)
//   store_pulse                : one-cycle strobe to load the secret register
//   state                      : current game_state_t
//   attempts                   : submits made in the current round
//   hint                       : {lt,gt,eq} captured at the last accepted submit
//   won, lost                  : round outcome flags
// All outputs are registered.
module guess_round_ctrl
    import guess_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_TRIES       = 7
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       key_store_n,
    input  logic       key_submit_n,
    input  logic       eq,
    input  logic       gt,
    input  logic       lt,
    output logic       store_pulse,
    output logic [1:0] state,
    output logic [3:0] attempts,
    output logic [2:0] hint,
    output logic       won,
    output logic       lost
);

    localparam logic [3:0] MAX_T = 4'(MAX_TRIES);

    logic        store_press;
    logic        submit_press;
    game_state_t state_q;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_store_key (
        .CLOCK_50    (CLOCK_50),
        .rst_n       (rst_n),
        .key_n       (key_store_n),
        .press_pulse (store_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_submit_key (
        .CLOCK_50    (CLOCK_50),
        .rst_n       (rst_n),
        .key_n       (key_submit_n),
        .press_pulse (submit_press)
    );

    assign state = state_q;

    // Store has priority over submit in every state; a coincident submit is
    // dropped. eq is checked before the attempt limit so a correct last guess
    // wins. Since S_PLAY always leaves before attempts passes MAX_TRIES,
    // attempts cannot wrap.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            attempts    <= 4'd0;
            hint        <= 3'b000;
            store_pulse <= 1'b0;
            won         <= 1'b0;
            lost        <= 1'b0;
        end else begin
            store_pulse <= 1'b0;
            if (store_press) begin
                store_pulse <= 1'b1;
                attempts    <= 4'd0;
                hint        <= 3'b000;
                state_q     <= S_PLAY;
                won         <= 1'b0;
                lost        <= 1'b0;
            end else if (submit_press && state_q == S_PLAY) begin
                attempts      <= attempts + 4'd1;
                hint[HINT_LT] <= lt;
                hint[HINT_GT] <= gt;
                hint[HINT_EQ] <= eq;
                if (eq) begin
                    state_q <= S_WON;
                    won     <= 1'b1;
                end else if (attempts + 4'd1 == MAX_T) begin
                    state_q <= S_LOST;
                    lost    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_guess_round_ctrl.sv
// tb_guess_round_ctrl: self-checking bench for guess_round_ctrl with
// DEBOUNCE_CYCLES=4 and MAX_TRIES=3.
module tb_guess_round_ctrl;
    import guess_pkg::*;

    localparam int DEB = 4;
    localparam int MAXT = 3;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst_n;
    logic       key_store_n;
    logic       key_submit_n;
    logic       eq, gt, lt;
    logic       store_pulse;
    logic [1:0] state;
    logic [3:0] attempts;
    logic [2:0] led_hint;
    logic       won, lost;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    guess_round_ctrl #(.DEBOUNCE_CYCLES(DEB), .MAX_TRIES(MAXT)) dut (
        .CLOCK_50     (clk),
        .rst_n        (rst_n),
        .key_store_n  (key_store_n),
        .key_submit_n (key_submit_n),
        .eq           (eq),
        .gt           (gt),
        .lt           (lt),
        .store_pulse  (store_pulse),
        .state        (state),
        .attempts     (attempts),
        .hint         (led_hint),
        .won          (won),
        .lost         (lost)
    );

    // ---------------- scoreboard ----------------
    // snapshot layout: {state[1:0], attempts[3:0], led_hint[2:0], won, lost}
    logic [10:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int store_cnt = 0;

    always @(negedge clk) begin
        if (store_pulse === 1'b1) store_cnt++;
    end

    function automatic logic [10:0] snap();
        return {state, attempts, led_hint, won, lost};
    endfunction

    function automatic logic [10:0] mk(input logic [1:0] s, input logic [3:0] a,
                                       input logic [2:0] h, input logic w, input logic l);
        return {s, a, h, w, l};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Hold the selected key(s) low for `hold` cycles, release, then let the
    // release debounce settle before returning on a falling clock edge.
    task automatic press(input logic do_store, input logic do_submit, input int hold);
        @(posedge clk); #1;
        if (do_store)  key_store_n  = 1'b0;
        if (do_submit) key_submit_n = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        key_store_n  = 1'b1;
        key_submit_n = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
    endtask

    // scoreboard step: push expected, drive, pop and compare
    task automatic step(input string name, input logic do_store, input logic do_submit,
                        input logic [2:0] cmp, input logic [10:0] exp_v);
        int c0;
        logic [10:0] e;
        c0 = store_cnt;
        {lt, gt, eq} = cmp;
        exp_q.push_back(exp_v);
        press(do_store, do_submit, 10);
        e = exp_q.pop_front();
        check(name, 32'(snap()), 32'(e));
        check({name, "_pulses"}, 32'(store_cnt - c0), 32'(do_store));
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic       st;
        logic       sub;
        logic [2:0] cmp;   // {lt,gt,eq}
        logic [1:0] e_state;
        logic [3:0] e_att;
        logic [2:0] e_hint;
        logic       e_won;
        logic       e_lost;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int t0;
        int first_k;
        int n_pulse;

        vecs[0]  = '{1'b0, 1'b1, 3'b010, S_PLAY, 4'd1, 3'b010, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 3'b100, S_PLAY, 4'd2, 3'b100, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 3'b010, S_LOST, 4'd3, 3'b010, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 3'b001, S_LOST, 4'd3, 3'b010, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 3'b000, S_PLAY, 4'd0, 3'b000, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 3'b010, S_PLAY, 4'd1, 3'b010, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3'b001, S_WON,  4'd2, 3'b001, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 3'b100, S_WON,  4'd2, 3'b001, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'b000, S_PLAY, 4'd0, 3'b000, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3'b100, S_PLAY, 4'd1, 3'b100, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 3'b010, S_PLAY, 4'd2, 3'b010, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 3'b001, S_WON,  4'd3, 3'b001, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 3'b000, S_PLAY, 4'd0, 3'b000, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 3'b110, S_PLAY, 4'd1, 3'b110, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 3'b010, S_PLAY, 4'd0, 3'b000, 1'b0, 1'b0};

        rst_n = 1'b0;
        key_store_n = 1'b1;
        key_submit_n = 1'b1;
        {lt, gt, eq} = 3'b000;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'(snap()), 32'(mk(S_IDLE, 4'd0, 3'b000, 1'b0, 1'b0)));
        check("reset_store_pulse", 32'(store_pulse), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);

        // submit is ignored while idle
        step("idle_submit", 1'b0, 1'b1, 3'b001, mk(S_IDLE, 4'd0, 3'b000, 1'b0, 1'b0));

        // first store press: synchroniser (2) + debounce (4) + press pulse (1)
        // puts the press pulse 7 edges after the key falls, store_pulse one later
        t0 = store_cnt;
        first_k = -1;
        n_pulse = 0;
        @(posedge clk); #1;
        key_store_n = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (store_pulse === 1'b1) begin
                n_pulse++;
                if (first_k < 0) first_k = k;
            end
            if (k == 10) key_store_n = 1'b1;
        end
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("store_pulse_count", 32'(n_pulse), 32'd1);
        check("store_pulse_latency", 32'(first_k), 32'd8);
        check("after_first_store", 32'(snap()), 32'(mk(S_PLAY, 4'd0, 3'b000, 1'b0, 1'b0)));
        check("first_store_monitor", 32'(store_cnt - t0), 32'd1);

        // short glitch on submit is rejected
        {lt, gt, eq} = 3'b010;
        exp_q.push_back(mk(S_PLAY, 4'd0, 3'b000, 1'b0, 1'b0));
        press(1'b0, 1'b1, 2);
        check("submit_glitch", 32'(snap()), 32'(exp_q.pop_front()));

        // table-driven round sequences
        for (int i = 0; i < 15; i++) begin
            step($sformatf("row%0d", i), vecs[i].st, vecs[i].sub, vecs[i].cmp,
                 mk(vecs[i].e_state, vecs[i].e_att, vecs[i].e_hint, vecs[i].e_won, vecs[i].e_lost));
        end

        // reset while WON with store held through reset release
        step("pre_reset_store", 1'b1, 1'b0, 3'b000, mk(S_PLAY, 4'd0, 3'b000, 1'b0, 1'b0));
        step("pre_reset_win", 1'b0, 1'b1, 3'b001, mk(S_WON, 4'd1, 3'b001, 1'b1, 1'b0));
        t0 = store_cnt;
        @(posedge clk); #1;
        key_store_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'(snap()), 32'(mk(S_IDLE, 4'd0, 3'b000, 1'b0, 1'b0)));
        check("async_reset_pulse", 32'(store_pulse), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("held_key_no_pulse", 32'(store_cnt - t0), 32'd0);
        check("held_key_state", 32'(snap()), 32'(mk(S_IDLE, 4'd0, 3'b000, 1'b0, 1'b0)));
        key_store_n = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("release_no_pulse", 32'(store_cnt - t0), 32'd0);
        step("repress_store", 1'b1, 1'b0, 3'b000, mk(S_PLAY, 4'd0, 3'b000, 1'b0, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
